// File: rtl/ms53l_frame_parser.sv
// Distance-sensor UART frame parser: two header bytes, eight body bytes, and an
// 8-bit additive checksum. Outputs the last good distance, plus error pulses and a good-frame count.
module ms53l_frame_parser #(
  parameter logic [7:0]  HDR_BYTE    = 8'h5A,
  parameter int unsigned TIMEOUT_CYC = 104166
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [15:0] dist_mm,
  output logic        dist_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  ok_cnt,
  output logic [1:0]  state_dbg
);
  // rx_valid is a one-cycle strobe with no back-pressure: every strobe is one
  // byte, consumed in the cycle it appears, including strobes on consecutive cycles.

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR2 = 2'd1, BODY = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [7:0]    sum, sum_nxt;
  logic [7:0]    d_hi, d_hi_nxt, d_lo, d_lo_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit, good, bad, tmo;

  assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT_CYC));
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sum_nxt   = sum;
    d_hi_nxt  = d_hi;
    d_lo_nxt  = d_lo;
    good      = 1'b0;
    bad       = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && rx_byte == HDR_BYTE) begin
          state_nxt = HDR2;
          sum_nxt   = HDR_BYTE;
        end
      end
      HDR2: begin
        if (rx_valid) begin
          if (rx_byte == HDR_BYTE) begin
            state_nxt = BODY;
            idx_nxt   = 4'd2;
            sum_nxt   = sum + rx_byte;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          tmo       = 1'b1;
        end
      end
      BODY: begin
        // A header-valued byte here is plain data; no resync mid-body.
        if (rx_valid) begin
          if (idx == 4'd10) begin
            state_nxt = IDLE;
            good      = (rx_byte == sum);
            bad       = (rx_byte != sum);
          end else begin
            sum_nxt = sum + rx_byte;
            idx_nxt = idx + 4'd1;
            if (idx == 4'd7) d_hi_nxt = rx_byte;
            if (idx == 4'd8) d_lo_nxt = rx_byte;
          end
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          tmo       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 4'd0;
      sum   <= 8'd0;
      d_hi  <= 8'd0;
      d_lo  <= 8'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      sum   <= sum_nxt;
      d_hi  <= d_hi_nxt;
      d_lo  <= d_lo_nxt;
    end
  end

  // Silence counter: a byte arriving in the cycle the limit is reached takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || rx_valid || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_mm    <= 16'd0;
      dist_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
      ok_cnt     <= 8'd0;
    end else begin
      dist_valid <= good;
      frame_err  <= bad | tmo;
      if (good) begin
        dist_mm <= {d_hi, d_lo};
        ok_cnt  <= ok_cnt + 8'd1;
      end
      if (bad) err_code <= 2'b01;
      if (tmo) err_code <= 2'b10;
    end
  end

endmodule

// File: doc/ms53l_frame_parser.md
MS53L_FRAME_PARSER -- requirements
Module: ms53l_frame_parser

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'h5A, frame header byte value (sent twice).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 104166, max clk cycles between bytes inside a frame (two byte times at 9600 baud, 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rx_valid  input  1  one-cycle pulse, byte available from UART receiver.
REQ-006 SHALL have port rx_byte  input  8  received byte, valid only when rx_valid=1.
REQ-007 SHALL have port dist_mm  output  16  last good distance, held between frames.
REQ-008 SHALL have port dist_valid  output  1  one-cycle pulse, dist_mm just updated.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, frame discarded.
REQ-010 SHALL have port err_code  output  2  cause of last error: 01 checksum, 10 timeout; held until next error.
REQ-011 SHALL have port ok_cnt  output  8  count of good frames, wraps 255->0.

Function
REQ-012 Frame SHALL be 11 bytes B0..B10: B0=B1=HDR_BYTE, B2..B6 ignored, B7 distance high, B8 distance low, B9 status (ignored), B10 checksum.
REQ-013 Checksum SHALL be the low 8 bits of the sum of B0..B9; carries discarded.
REQ-014 FSM states SHALL be IDLE, HDR2, BODY; reset state IDLE.
REQ-015 IDLE: rx_valid with rx_byte==HDR_BYTE -> HDR2; any other byte ignored, stay in IDLE.
REQ-016 HDR2: rx_valid with rx_byte==HDR_BYTE -> BODY, byte index=2; other byte -> IDLE, no error.
REQ-017 BODY: each rx_valid stores the byte at current index and increments the index; on index 10 (checksum byte) -> IDLE.
REQ-018 On checksum byte match: dist_mm<={B7,B8}, dist_valid=1, ok_cnt+1, all in the cycle after the rx_valid (latency 1).
REQ-019 On checksum mismatch: frame_err=1, err_code=01 in the cycle after the rx_valid; dist_mm, ok_cnt unchanged.
REQ-020 Inter-byte counter SHALL clear on every rx_valid and in IDLE, and count otherwise in HDR2/BODY.
REQ-021 Counter reaching TIMEOUT_CYC in HDR2 or BODY -> IDLE next cycle with frame_err=1, err_code=10; partial frame dropped.
REQ-022 rx_valid in the same cycle as timeout SHALL win: byte processed, counter cleared, no error.
REQ-023 Header search SHALL NOT restart mid-body: a HDR_BYTE value inside B2..B10 is data.
REQ-024 After any error or good frame, the next frame SHALL be accepted with no dead cycles.
REQ-025 rx_valid asserted on consecutive cycles SHALL each be processed as a separate byte.

Reset
REQ-026 On rst_n low: state IDLE, index 0, counter 0, running sum 0, dist_mm=0, dist_valid=0, frame_err=0, err_code=00, ok_cnt=0.
REQ-027 Reset asserted mid-frame SHALL drop the partial frame with no dist_valid or frame_err pulse after release.

Verification
REQ-028 Good frame 5A 5A 00 00 00 00 00 01 2C 00 E1 -> one dist_valid, dist_mm=16'd300, ok_cnt=1, no frame_err.
REQ-029 Same frame with B10=E2 -> frame_err=1 one cycle, err_code=01, dist_mm unchanged, ok_cnt unchanged.
REQ-030 Noise 00 5A 33 then good frame -> 5A 33 discarded silently, good frame gives dist_valid.
REQ-031 5A 5A plus 3 bytes, then silence of TIMEOUT_CYC cycles -> frame_err, err_code=10; following good frame accepted.
REQ-032 Good frame with B7=5A, B8=5A and correct checksum -> dist_mm=16'h5A5A, no resync.
REQ-033 256 good frames -> ok_cnt wraps to 0; reset asserted at byte 6 of frame 257 -> all outputs 0, no pulse.
